// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX/MEM pipeline stage.
package ex_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IDX_W  = 4;

  // Control fields carried alongside the payload.
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_write;
    logic mem_read;
  } ex_mem_ctrl_t;

  // Number of entries held by the stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ex_mem_state_t;

  // Occupancy count for a given state.
  function automatic logic [1:0] occ_of(input ex_mem_state_t s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// Handshake and payload bundle between execute (side 1) and memory (side 2).
interface ex_mem_pipe_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) ();

  logic              Flush;
  logic              InValid;
  logic              InReady;
  logic              RegWrite1;
  logic              MemotoReg1;
  logic              MemWrite1;
  logic              MemRead1;
  logic [DATA_W-1:0] Result1;
  logic [DATA_W-1:0] DataIn1;
  logic [IDX_W-1:0]  RegWriteIndex1;

  logic              OutValid;
  logic              OutReady;
  logic              RegWrite2;
  logic              MemotoReg2;
  logic              MemWrite2;
  logic              MemRead2;
  logic [DATA_W-1:0] Result2;
  logic [DATA_W-1:0] DataIn2;
  logic [IDX_W-1:0]  RegWriteIndex2;
  logic [1:0]        Occupancy;

  // Environment side: drives the execute-side inputs and the memory-side ready.
  modport master (
    output Flush, InValid, RegWrite1, MemotoReg1, MemWrite1, MemRead1,
           Result1, DataIn1, RegWriteIndex1, OutReady,
    input  InReady, OutValid, RegWrite2, MemotoReg2, MemWrite2, MemRead2,
           Result2, DataIn2, RegWriteIndex2, Occupancy
  );

  // Pipeline stage side.
  modport slave (
    input  Flush, InValid, RegWrite1, MemotoReg1, MemWrite1, MemRead1,
           Result1, DataIn1, RegWriteIndex1, OutReady,
    output InReady, OutValid, RegWrite2, MemotoReg2, MemWrite2, MemRead2,
           Result2, DataIn2, RegWriteIndex2, Occupancy
  );

endinterface

// File: rtl/ex_mem_slot.sv
// One payload register with load enable; clears to zero on reset.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the payload when loaded, otherwise hold.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: valid/ready handshake with a two-entry skid buffer,
// synchronous flush and bubble-gated control outputs. InReady is registered so
// the memory stage's ready never reaches execute combinationally.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input logic           Clk,
  input logic           Rst,
  ex_mem_pipe_if.slave  bus
);

  localparam int SLOT_W = $bits(ex_mem_ctrl_t) + 2 * DATA_W + IDX_W;

  ex_mem_state_t     state_q;
  ex_mem_state_t     state_d;
  logic              in_ready_q;
  logic              out_valid;
  logic              xfer_in;
  logic              xfer_out;
  logic              main_load;
  logic              skid_load;
  logic              main_from_skid;
  logic [1:0]        occupancy;

  ex_mem_ctrl_t      in_ctrl;
  ex_mem_ctrl_t      main_ctrl;
  logic [SLOT_W-1:0] in_slot;
  logic [SLOT_W-1:0] main_d;
  logic [SLOT_W-1:0] main_p1;
  logic [SLOT_W-1:0] skid_p1;
  logic [DATA_W-1:0] main_result;
  logic [DATA_W-1:0] main_data;
  logic [IDX_W-1:0]  main_idx;

  assign in_ctrl = '{reg_write: bus.RegWrite1, memto_reg: bus.MemotoReg1,
                     mem_write: bus.MemWrite1, mem_read:  bus.MemRead1};
  assign in_slot = {in_ctrl, bus.Result1, bus.DataIn1, bus.RegWriteIndex1};
  assign main_d  = main_from_skid ? skid_p1 : in_slot;
  assign {main_ctrl, main_result, main_data, main_idx} = main_p1;

  assign out_valid = (state_q != EMPTY);
  assign xfer_in   = bus.InValid & in_ready_q & ~bus.Flush;
  assign xfer_out  = out_valid & bus.OutReady;

  // State register and registered ready (ready = next state is not full).
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Next-state: flush wins over every other transition.
  always_comb begin
    state_d = state_q;
    if (bus.Flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (xfer_in) state_d = ONE;
        ONE: begin
          if (xfer_in && !xfer_out)      state_d = TWO;
          else if (!xfer_in && xfer_out) state_d = EMPTY;
        end
        TWO:     if (xfer_out) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Slot load enables and occupancy for the current state.
  always_comb begin
    occupancy      = occ_of(state_q);
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (!bus.Flush) begin
      case (state_q)
        EMPTY: main_load = xfer_in;
        ONE: begin
          main_load = xfer_in & xfer_out;
          skid_load = xfer_in & ~xfer_out;
        end
        TWO: begin
          main_load      = xfer_out;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage boundary: main slot drives the outputs, skid absorbs one overflow entry.
  ex_mem_slot #(.W(SLOT_W)) u_main (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_p1)
  );

  ex_mem_slot #(.W(SLOT_W)) u_skid (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (skid_load),
    .d    (in_slot),
    .q    (skid_p1)
  );

  assign bus.InReady        = in_ready_q;
  assign bus.OutValid       = out_valid;
  assign bus.Occupancy      = occupancy;
  assign bus.RegWrite2      = main_ctrl.reg_write & out_valid;
  assign bus.MemotoReg2     = main_ctrl.memto_reg & out_valid;
  assign bus.MemWrite2      = main_ctrl.mem_write & out_valid;
  assign bus.MemRead2       = main_ctrl.mem_read  & out_valid;
  assign bus.Result2        = main_result;
  assign bus.DataIn2        = main_data;
  assign bus.RegWriteIndex2 = main_idx;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: default 16/4 instance plus a 32/5 instance.
module tb_ex_mem_pipe;

  logic Clk = 1'b0;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  ex_mem_pipe_if                          b16 ();
  ex_mem_pipe_if #(.DATA_W(32), .IDX_W(5)) b32 ();

  ex_mem_pipe u16 (.Clk(Clk), .Rst(Rst), .bus(b16));
  ex_mem_pipe #(.DATA_W(32), .IDX_W(5)) u32 (.Clk(Clk), .Rst(Rst), .bus(b32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drv16(input logic v, input logic [15:0] res, input logic [3:0] ctrl,
                       input logic [3:0] idx, input logic [15:0] din);
    b16.InValid        = v;
    b16.Result1        = res;
    b16.DataIn1        = din;
    b16.RegWriteIndex1 = idx;
    {b16.RegWrite1, b16.MemotoReg1, b16.MemWrite1, b16.MemRead1} = ctrl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    b16.Flush = 1'b0; b16.OutReady = 1'b0;
    drv16(1'b0, 16'h0, 4'h0, 4'h0, 16'h0);
    b32.Flush = 1'b0; b32.OutReady = 1'b0; b32.InValid = 1'b0;
    b32.Result1 = '0; b32.DataIn1 = '0; b32.RegWriteIndex1 = '0;
    b32.RegWrite1 = 1'b0; b32.MemotoReg1 = 1'b0; b32.MemWrite1 = 1'b0; b32.MemRead1 = 1'b0;
    #2;
    chk("rst_outvalid",  b16.OutValid,  1'b0);
    chk("rst_inready",   b16.InReady,   1'b1);
    chk("rst_occ",       b16.Occupancy, 2'd0);
    chk("rst_result",    b16.Result2,   16'h0);
    chk("rst_regwrite",  b16.RegWrite2, 1'b0);
    step(); step();
    Rst = 1'b0;

    // Stream four entries with the memory stage always ready.
    b16.OutReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drv16(1'b1, 16'(i), 4'h0, 4'(i), 16'(16'h0100 + i));
      step();
      chk("stream_valid",  b16.OutValid,       1'b1);
      chk("stream_result", b16.Result2,        64'(i));
      chk("stream_data",   b16.DataIn2,        64'(16'h0100 + i));
      chk("stream_idx",    b16.RegWriteIndex2, 64'(i));
      chk("stream_occ",    b16.Occupancy,      2'd1);
      chk("stream_ready",  b16.InReady,        1'b1);
    end
    drv16(1'b0, 16'h0, 4'h0, 4'h0, 16'h0);
    step();
    chk("stream_drain_valid", b16.OutValid,  1'b0);
    chk("stream_drain_occ",   b16.Occupancy, 2'd0);

    // Stall fill: two entries pile up, third is refused.
    b16.OutReady = 1'b0;
    drv16(1'b1, 16'h00A1, 4'h0, 4'h1, 16'h0);
    step();
    chk("stall1_result", b16.Result2,   16'h00A1);
    chk("stall1_occ",    b16.Occupancy, 2'd1);
    chk("stall1_ready",  b16.InReady,   1'b1);
    drv16(1'b1, 16'h00A2, 4'h0, 4'h2, 16'h0);
    step();
    chk("stall2_occ",    b16.Occupancy, 2'd2);
    chk("stall2_ready",  b16.InReady,   1'b0);
    chk("stall2_result", b16.Result2,   16'h00A1);
    drv16(1'b1, 16'h00A3, 4'h0, 4'h3, 16'h0);
    step();
    chk("stall3_occ",    b16.Occupancy, 2'd2);
    chk("stall3_valid",  b16.OutValid,  1'b1);
    chk("stall3_result", b16.Result2,   16'h00A1);
    drv16(1'b0, 16'h0, 4'h0, 4'h0, 16'h0);
    b16.OutReady = 1'b1;
    step();
    chk("drain1_result", b16.Result2,   16'h00A2);
    chk("drain1_idx",    b16.RegWriteIndex2, 4'h2);
    chk("drain1_occ",    b16.Occupancy, 2'd1);
    chk("drain1_ready",  b16.InReady,   1'b1);
    step();
    chk("drain2_valid",  b16.OutValid,  1'b0);
    chk("drain2_occ",    b16.Occupancy, 2'd0);

    // Flush while full, with a new entry offered in the same cycle.
    b16.OutReady = 1'b0;
    drv16(1'b1, 16'h00B1, 4'hF, 4'h1, 16'h0);
    step();
    drv16(1'b1, 16'h00B2, 4'hF, 4'h2, 16'h0);
    step();
    chk("flush_pre_occ", b16.Occupancy, 2'd2);
    chk("flush_pre_rw",  b16.RegWrite2, 1'b1);
    b16.Flush = 1'b1;
    drv16(1'b1, 16'h00B3, 4'hF, 4'h3, 16'h0);
    step();
    b16.Flush = 1'b0;
    drv16(1'b0, 16'h0, 4'h0, 4'h0, 16'h0);
    chk("flush_valid",  b16.OutValid,   1'b0);
    chk("flush_ctrl",   {b16.RegWrite2, b16.MemotoReg2, b16.MemWrite2, b16.MemRead2}, 4'h0);
    chk("flush_occ",    b16.Occupancy,  2'd0);
    chk("flush_ready",  b16.InReady,    1'b1);
    chk("flush_hold",   b16.Result2,    16'h00B1);
    step();
    chk("flush_nob3_valid", b16.OutValid, 1'b0);
    chk("flush_nob3_res",   b16.Result2,  16'h00B1);

    // Bubble gating: control drops after consumption, data holds.
    b16.OutReady = 1'b1;
    drv16(1'b1, 16'h00C4, 4'b1010, 4'h7, 16'h5555);
    step();
    chk("bub_valid", b16.OutValid,  1'b1);
    chk("bub_mw",    b16.MemWrite2, 1'b1);
    chk("bub_rw",    b16.RegWrite2, 1'b1);
    chk("bub_mr",    b16.MemRead2,  1'b0);
    drv16(1'b0, 16'h0, 4'h0, 4'h0, 16'h0);
    step();
    chk("bub_idle_valid", b16.OutValid,  1'b0);
    chk("bub_idle_mw",    b16.MemWrite2, 1'b0);
    chk("bub_idle_rw",    b16.RegWrite2, 1'b0);
    chk("bub_idle_res",   b16.Result2,   16'h00C4);
    chk("bub_idle_data",  b16.DataIn2,   16'h5555);

    // Asynchronous reset while full.
    b16.OutReady = 1'b0;
    drv16(1'b1, 16'h00D1, 4'hF, 4'h9, 16'h1111);
    step();
    drv16(1'b1, 16'h00D2, 4'hF, 4'hA, 16'h2222);
    step();
    chk("arst_pre_occ", b16.Occupancy, 2'd2);
    #3;
    Rst = 1'b1;
    #1;
    chk("arst_valid",  b16.OutValid,       1'b0);
    chk("arst_ready",  b16.InReady,        1'b1);
    chk("arst_occ",    b16.Occupancy,      2'd0);
    chk("arst_result", b16.Result2,        16'h0);
    chk("arst_data",   b16.DataIn2,        16'h0);
    chk("arst_idx",    b16.RegWriteIndex2, 4'h0);
    chk("arst_ctrl",   {b16.RegWrite2, b16.MemotoReg2, b16.MemWrite2, b16.MemRead2}, 4'h0);
    step();
    chk("arst_hold_occ", b16.Occupancy, 2'd0);
    Rst = 1'b0;
    drv16(1'b0, 16'h0, 4'h0, 4'h0, 16'h0);

    // Wide instance: stall fill with 32-bit payload and 5-bit index.
    b32.OutReady = 1'b0;
    b32.InValid = 1'b1; b32.Result1 = 32'hDEADBEEF; b32.DataIn1 = 32'h12345678;
    b32.RegWriteIndex1 = 5'd31; b32.RegWrite1 = 1'b1;
    step();
    b32.Result1 = 32'hCAFEF00D; b32.DataIn1 = 32'h87654321; b32.RegWriteIndex1 = 5'd30;
    step();
    b32.InValid = 1'b0;
    chk("w_occ",    b32.Occupancy,      2'd2);
    chk("w_ready",  b32.InReady,        1'b0);
    chk("w_result", b32.Result2,        32'hDEADBEEF);
    chk("w_data",   b32.DataIn2,        32'h12345678);
    chk("w_idx",    b32.RegWriteIndex2, 5'd31);
    chk("w_rw",     b32.RegWrite2,      1'b1);
    b32.OutReady = 1'b1;
    step();
    chk("w_drain_result", b32.Result2,        32'hCAFEF00D);
    chk("w_drain_data",   b32.DataIn2,        32'h87654321);
    chk("w_drain_idx",    b32.RegWriteIndex2, 5'd30);
    chk("w_drain_ready",  b32.InReady,        1'b1);
    step();
    chk("w_empty_valid",  b32.OutValid,       1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
